// File: rtl/uart_line_decoder.sv
// uart_line_decoder: passive 8N1 UART line monitor; decodes bytes from a serial pad.
// Ports: clk/rst_n (async active-low), uart_tx (monitored line), data_o/valid_o/newline_o
//        (received byte and strobes), frame_err_o (bad stop bit), busy_o, byte_count_o.
module uart_line_decoder #(
  parameter int CLK_PERIOD_NS           = 20,
  parameter int UART_BAUDRATE_PERIOD_NS = 4340
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_tx,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        newline_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic [15:0] byte_count_o
);

  localparam int BIT_CLKS  = UART_BAUDRATE_PERIOD_NS / CLK_PERIOD_NS;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS) + 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             sync1, sync2;
  logic             line;
  logic             tick;
  // One-cycle flags from the stop-bit decision; the user-visible strobes are
  // registered from these, so they appear one cycle after the stop sample.
  logic             byte_ok, byte_ok_nxt;
  logic             stop_bad, stop_bad_nxt;

  assign line   = sync2;
  assign tick   = (cnt == '0);
  assign busy_o = (state != IDLE);

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_tx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      byte_ok  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      shreg    <= shreg_nxt;
      byte_ok  <= byte_ok_nxt;
      stop_bad <= stop_bad_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = tick ? cnt : cnt - 1'b1;
    idx_nxt      = idx;
    shreg_nxt    = shreg;
    byte_ok_nxt  = 1'b0;
    stop_bad_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!line) begin
          state_nxt = START;
          cnt_nxt   = HALF_RELOAD;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (tick) begin
          if (!line) begin
            state_nxt = DATA;
            cnt_nxt   = BIT_RELOAD;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt = {line, shreg[7:1]};
          cnt_nxt   = BIT_RELOAD;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (line) begin
            byte_ok_nxt  = 1'b1;
            state_nxt    = IDLE;
          end else begin
            stop_bad_nxt = 1'b1;
            state_nxt    = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line recovers so a stuck-low line reports once.
        if (line) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shreg is stable here: the next frame cannot reach DATA for over half a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      newline_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      byte_count_o <= 16'h0000;
    end else begin
      valid_o     <= byte_ok;
      newline_o   <= byte_ok && (shreg == 8'h0A);
      frame_err_o <= stop_bad;
      if (byte_ok) begin
        data_o       <= shreg;
        byte_count_o <= byte_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_line_decoder.sv
module tb_uart_line_decoder;

  localparam int BIT = 217;

  logic        clk;
  logic        rst_n;
  logic        uart_tx;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        newline_o;
  logic        frame_err_o;
  logic        busy_o;
  logic [15:0] byte_count_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [7:0] vq[$];
  logic       nlq[$];
  int         vcyc[$];
  int         ferr_n   = 0;
  int         ferr_cyc = 0;
  int         busy_n   = 0;

  uart_line_decoder #(
    .CLK_PERIOD_NS(20),
    .UART_BAUDRATE_PERIOD_NS(4340)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_tx(uart_tx),
    .data_o(data_o),
    .valid_o(valid_o),
    .newline_o(newline_o),
    .frame_err_o(frame_err_o),
    .busy_o(busy_o),
    .byte_count_o(byte_count_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      vq.push_back(data_o);
      nlq.push_back(newline_o);
      vcyc.push_back(cyc);
    end
    if (frame_err_o) begin
      ferr_n++;
      ferr_cyc = cyc;
    end
    if (busy_o) busy_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    vq.delete();
    nlq.delete();
    vcyc.delete();
    ferr_n = 0;
    busy_n = 0;
  endtask

  // Frame starts on a negedge; t0 is the number of the next rising edge (cycle 0).
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_cycles);
    @(negedge clk);
    uart_tx = 1'b0;
    t0 = cyc + 1;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_tx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_tx = stop_val;
    repeat (stop_cycles) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_tx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data",  {24'h0, data_o}, 32'h00);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_nl",    {31'h0, newline_o}, 32'h0);
    check("rst_ferr",  {31'h0, frame_err_o}, 32'h0);
    check("rst_busy",  {31'h0, busy_o}, 32'h0);
    check("rst_count", {16'h0, byte_count_o}, 32'h0);

    // Single byte 0x41 with exact strobe timing
    clear_log();
    send_byte(8'h41, 1'b1, BIT);
    repeat (20) @(negedge clk);
    check("a_pulses", vq.size(), 1);
    if (vq.size() == 1) begin
      check("a_data",  {24'h0, vq[0]}, 32'h41);
      check("a_cycle", vcyc[0], t0 + 2064);
      check("a_nl",    {31'h0, nlq[0]}, 32'h0);
    end
    check("a_data_hold", {24'h0, data_o}, 32'h41);
    check("a_count", {16'h0, byte_count_o}, 32'd1);
    check("a_ferr",  ferr_n, 0);

    // Back-to-back "Hi\n"
    clear_log();
    send_byte(8'h48, 1'b1, BIT - 1);
    send_byte(8'h69, 1'b1, BIT - 1);
    send_byte(8'h0A, 1'b1, BIT);
    repeat (20) @(negedge clk);
    check("hi_pulses", vq.size(), 3);
    if (vq.size() == 3) begin
      check("hi_d0", {24'h0, vq[0]}, 32'h48);
      check("hi_d1", {24'h0, vq[1]}, 32'h69);
      check("hi_d2", {24'h0, vq[2]}, 32'h0A);
      check("hi_nl0", {31'h0, nlq[0]}, 32'h0);
      check("hi_nl1", {31'h0, nlq[1]}, 32'h0);
      check("hi_nl2", {31'h0, nlq[2]}, 32'h1);
    end
    check("hi_count", {16'h0, byte_count_o}, 32'd4);

    // 50-cycle glitch on idle line
    clear_log();
    @(negedge clk);
    uart_tx = 1'b0;
    repeat (50) @(negedge clk);
    uart_tx = 1'b1;
    repeat (300) @(negedge clk);
    check("gl_busy_seen", (busy_n > 0), 1);
    check("gl_pulses", vq.size(), 0);
    check("gl_ferr", ferr_n, 0);
    check("gl_data", {24'h0, data_o}, 32'h0A);
    check("gl_busy_end", {31'h0, busy_o}, 32'h0);

    // 0x55 with stop bit low, line held low
    clear_log();
    send_byte(8'h55, 1'b0, 5000);
    check("fe_count", ferr_n, 1);
    check("fe_cycle", ferr_cyc, t0 + 2064);
    check("fe_pulses", vq.size(), 0);
    check("fe_busy_low", {31'h0, busy_o}, 32'h1);
    check("fe_data", {24'h0, data_o}, 32'h0A);
    uart_tx = 1'b1;
    repeat (5) @(negedge clk);
    check("fe_busy_rel", {31'h0, busy_o}, 32'h0);
    clear_log();
    send_byte(8'h33, 1'b1, BIT);
    repeat (20) @(negedge clk);
    check("rc_pulses", vq.size(), 1);
    check("rc_data", {24'h0, data_o}, 32'h33);
    check("rc_count", {16'h0, byte_count_o}, 32'd5);
    check("rc_ferr", ferr_n, 0);

    // Reset asserted mid-DATA
    clear_log();
    @(negedge clk);
    uart_tx = 1'b0;
    repeat (600) @(negedge clk);
    check("md_busy_pre", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("md_busy_rst", {31'h0, busy_o}, 32'h0);
    check("md_count_rst", {16'h0, byte_count_o}, 32'h0);
    check("md_data_rst", {24'h0, data_o}, 32'h00);
    uart_tx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    check("md_pulses", vq.size(), 0);
    check("md_busy_end", {31'h0, busy_o}, 32'h0);

    // Counter wrap: preload 0xFFFF, then one more byte
    @(negedge clk);
    force dut.byte_count_o = 16'hFFFF;
    @(negedge clk);
    release dut.byte_count_o;
    clear_log();
    send_byte(8'h7E, 1'b1, BIT);
    repeat (20) @(negedge clk);
    check("wr_pulses", vq.size(), 1);
    check("wr_data", {24'h0, data_o}, 32'h7E);
    check("wr_count", {16'h0, byte_count_o}, 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
